// File: rtl/skencode_ctrl_pkg.sv
// Shared constants, state type and the t0 encoder for the sk t0 encoder.
// No ports; imported by skencode_bitpack_buf and power2round_skencode_ctrl.
package skencode_ctrl_pkg;

    localparam int COEF_W         = 13;
    localparam int COEFS_PER_BEAT = 4;
    localparam int BEAT_W         = 52;
    localparam int WORD_W         = 32;
    localparam int BUF_W          = 96;
    localparam int BEATS_PER_POLY = 64;
    localparam int WORDS_PER_POLY = 104;
    localparam logic [COEF_W-1:0] ENC_OFFSET = 13'h1000;

    // Fill count never exceeds BUF_W (96), so 7 bits suffice.
    localparam int FILL_W = 7;

    // A beat may be inserted only if it fits entirely behind the post-drain contents.
    localparam int READY_MAX_FILL = BUF_W - BEAT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // 2^12 - r0, wrapping modulo 2^13.
    function automatic logic [COEF_W-1:0] t0_encode(input logic [COEF_W-1:0] r0);
        return ENC_OFFSET - r0;
    endfunction

endpackage

// File: rtl/skencode_bitpack_buf.sv
// 96-bit little-endian bit-pack accumulator for encoded t0 beats.
// Each cycle with fill >= 32 the low word is offered on drain_word and the
// buffer shifts right by 32; an accepted beat is inserted behind whatever
// remains after that drain, in the same cycle.
// Ports:
//   clk, rst           clock, async active-high reset
//   clr                synchronous clear of contents and fill
//   run                accepting beats is allowed (controller in RUN)
//   beat_valid/_data   52-bit encoded beat from the controller
//   beat_ready         ready toward upstream (registers only)
//   beat_accept        beat_valid && beat_ready
//   drain              low word is being consumed this cycle
//   drain_word         current low 32 bits of the buffer
module skencode_bitpack_buf
    import skencode_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic              beat_ready,
    output logic              beat_accept,
    output logic              drain,
    output logic [WORD_W-1:0] drain_word
);

    logic [BUF_W-1:0]  pack_q;
    logic [BUF_W-1:0]  pack_d;
    logic [BUF_W-1:0]  pack_shifted;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_after_drain;

    always_comb begin
        drain            = (fill_q >= FILL_W'(WORD_W));
        fill_after_drain = drain ? (fill_q - FILL_W'(WORD_W)) : fill_q;
        pack_shifted     = drain ? (pack_q >> WORD_W) : pack_q;
        beat_ready       = run && (fill_after_drain <= FILL_W'(READY_MAX_FILL));
        beat_accept      = beat_valid && beat_ready;

        pack_d = pack_shifted;
        fill_d = fill_after_drain;
        if (beat_accept) begin
            // Bits above the live contents are always zero, so OR-insert is safe.
            pack_d = pack_shifted | ({{(BUF_W-BEAT_W){1'b0}}, beat_data} << fill_after_drain);
            fill_d = fill_after_drain + FILL_W'(BEAT_W);
        end
        if (clr) begin
            pack_d = '0;
            fill_d = '0;
        end
    end

    assign drain_word = pack_q[WORD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q <= '0;
            fill_q <= '0;
        end else begin
            pack_q <= pack_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/power2round_skencode_ctrl.sv
// Sequences ML-DSA sk t0 encoding: accepts four 13-bit power2round low parts
// per beat, encodes each as 2^12 - r0 mod 2^13, bit-packs little-endian into
// 32-bit words and writes NUM_POLY*104 words starting at base_addr.
// Optional build macro SKENCODE_CTRL_ZEROIZE_EN adds the zeroize input.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, base_addr         run request (IDLE only) and first write address
//   coef_valid/_data/_ready  52-bit beat stream of four r0 values
//   zeroize                  (macro only) synchronous wipe and abort
//   sk_wr_en/_addr/_data     registered sk memory write port
//   busy                     high in RUN and DRAIN
//   done                     one-cycle pulse after the final write
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | accepting beats and writing words
// S_DRAIN | all beats in; writing out remaining words
// S_DONE  | one-cycle completion pulse
module power2round_skencode_ctrl
    import skencode_ctrl_pkg::*;
#(
    parameter int NUM_POLY = 8,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              coef_valid,
    input  logic [BEAT_W-1:0] coef_data,
`ifdef SKENCODE_CTRL_ZEROIZE_EN
    input  logic              zeroize,
`endif
    output logic              coef_ready,
    output logic              sk_wr_en,
    output logic [ADDR_W-1:0] sk_wr_addr,
    output logic [WORD_W-1:0] sk_wr_data,
    output logic              busy,
    output logic              done
);

    localparam int BEAT_CNT_W = 7 + $clog2(NUM_POLY);
    localparam int WORD_CNT_W = $clog2(WORDS_PER_POLY * NUM_POLY);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_POLY * NUM_POLY - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(WORDS_PER_POLY * NUM_POLY - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic                    start_ok;
    logic                    zero_req;
    logic [ADDR_W-1:0]       base_q;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q;
    logic [WORD_CNT_W-1:0]   word_cnt_q;
    logic                    last_wr_q;
    logic [BEAT_W-1:0]       enc_beat;
    logic                    beat_accept;
    logic                    drain;
    logic                    issue;
    logic [WORD_W-1:0]       drain_word;

`ifdef SKENCODE_CTRL_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    for (genvar i = 0; i < COEFS_PER_BEAT; i++) begin : g_enc
        assign enc_beat[COEF_W*i +: COEF_W] = t0_encode(coef_data[COEF_W*i +: COEF_W]);
    end

    skencode_bitpack_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_ok || zero_req),
        .run         (state_q == S_RUN),
        .beat_valid  (coef_valid),
        .beat_data   (enc_beat),
        .beat_ready  (coef_ready),
        .beat_accept (beat_accept),
        .drain       (drain),
        .drain_word  (drain_word)
    );

    assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done  = (state_q == S_DONE);
    assign issue = drain && busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    start_ok = 1'b1;
                end
            end
            S_RUN: begin
                if (beat_accept && (beat_cnt_q == LAST_BEAT)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // last_wr_q is high while the final word sits on the write port.
                if (last_wr_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (zero_req) begin
            state_d  = S_IDLE;
            start_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            last_wr_q  <= 1'b0;
            sk_wr_en   <= 1'b0;
            sk_wr_addr <= '0;
            sk_wr_data <= '0;
        end else if (zero_req) begin
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            last_wr_q  <= 1'b0;
            sk_wr_en   <= 1'b0;
            sk_wr_addr <= '0;
            sk_wr_data <= '0;
        end else begin
            sk_wr_en  <= issue;
            last_wr_q <= issue && (word_cnt_q == LAST_WORD);
            if (start_ok) begin
                base_q     <= base_addr;
                beat_cnt_q <= '0;
                word_cnt_q <= '0;
            end else begin
                if (beat_accept) begin
                    beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
                end
                if (issue) begin
                    word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
                    sk_wr_data <= drain_word;
                    // Address arithmetic wraps modulo 2^ADDR_W.
                    sk_wr_addr <= base_q + ADDR_W'(word_cnt_q);
                end
            end
        end
    end

endmodule
